// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program counter, next-fetch address mux and subroutine return stack
module program_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       jmp,
    input  logic       jmp_nz,
    input  logic       call,
    input  logic       ret,
    input  logic [3:0] jmp_addr,
    input  logic       dont_jmp,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic [2:0] sp,
    output logic       stack_ovf,
    output logic       stack_unf,
    output logic [7:0] from_PS
);

    localparam int         IW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0] SP_FULL = 3'(STACK_DEPTH);

    logic [7:0] stack [STACK_DEPTH];
    logic [7:0] pc_inc;
    logic [7:0] target;
    logic [7:0] stack_top;
    logic       do_push;
    logic       do_pop;
    logic       set_ovf;
    logic       set_unf;

    assign pc_inc    = pc + 8'd1;
    assign target    = {jmp_addr, 4'h0};
    assign stack_top = stack[IW'(sp - 3'd1)];
    assign from_PS   = pc;

    // Only the highest-priority control acts; lower ones have no side effects.
    always_comb begin
        pm_addr = pc_inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (sync_reset) begin
            pm_addr = 8'h00;
        end else if (jmp) begin
            pm_addr = target;
        end else if (jmp_nz) begin
            pm_addr = dont_jmp ? pc_inc : target;
        end else if (call) begin
            pm_addr = target;
            if (sp == SP_FULL) begin
                set_ovf = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end else if (ret) begin
            if (sp == 3'd0) begin
                set_unf = 1'b1;
            end else begin
                pm_addr = stack_top;
                do_pop  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc        <= 8'h00;
            sp        <= 3'd0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            pc <= pm_addr;
            if (do_push) begin
                stack[IW'(sp)] <= pc_inc;
                sp             <= sp + 3'd1;
            end else if (do_pop) begin
                sp <= sp - 3'd1;
            end
            if (set_ovf) stack_ovf <= 1'b1;
            if (set_unf) stack_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - randomized and directed bench for program_sequencer
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       sync_reset, jmp, jmp_nz, call, ret, dont_jmp;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr, pc, from_PS;
    logic [2:0] sp;
    logic       stack_ovf, stack_unf;

    program_sequencer #(.STACK_DEPTH(4)) dut (
        .clk(clk), .sync_reset(sync_reset), .jmp(jmp), .jmp_nz(jmp_nz),
        .call(call), .ret(ret), .jmp_addr(jmp_addr), .dont_jmp(dont_jmp),
        .pm_addr(pm_addr), .pc(pc), .sp(sp), .stack_ovf(stack_ovf),
        .stack_unf(stack_unf), .from_PS(from_PS)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failures  = 0;

    // Reference model: integer pc, queue as the return stack.
    int         m_pc;
    int         m_stack[$];
    bit         m_ovf, m_unf;
    logic [7:0] exp_pm, obs_pm;

    wire [20:0] obs_state = {pc, sp, stack_ovf, stack_unf, from_PS};

    function automatic logic [20:0] exp_state();
        return {8'(m_pc), 3'(m_stack.size()), m_ovf, m_unf, 8'(m_pc)};
    endfunction

    task automatic cycle(input logic j, input logic jn, input logic c, input logic r,
                         input logic [3:0] a, input logic dj, input logic rst);
        int tgt;
        jmp = j; jmp_nz = jn; call = c; ret = r; jmp_addr = a; dont_jmp = dj; sync_reset = rst;
        #2;
        obs_pm = pm_addr;
        tgt = a * 16;
        if (rst) begin
            m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
        end else if (j) begin
            m_pc = tgt;
        end else if (jn) begin
            m_pc = dj ? (m_pc + 1) % 256 : tgt;
        end else if (c) begin
            if (m_stack.size() < 4) m_stack.push_back((m_pc + 1) % 256);
            else m_ovf = 1;
            m_pc = tgt;
        end else if (r && m_stack.size() > 0) begin
            m_pc = m_stack.pop_back();
        end else begin
            if (r) m_unf = 1;
            m_pc = (m_pc + 1) % 256;
        end
        exp_pm = 8'(m_pc);
        @(posedge clk);
        #1;
        jmp = 0; jmp_nz = 0; call = 0; ret = 0; sync_reset = 0;
    endtask

    task automatic idle_to(input int target);
        for (int i = 0; i < 300 && m_pc != target; i++) cycle(0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(0, 0, 1, 1, 4'h5, 0, 1);
        tests_run++;
        if (obs_pm !== 8'h00 || obs_state !== 21'h0) begin
            failures++;
            $display("FAIL reset: pm_addr=%h state=%h, expected pm_addr=00 state=000000", obs_pm, obs_state);
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(0, 0, 0, 0, 4'(i), 0, 0);
            if (pc !== 8'((i + 1) % 256) || sp !== 3'd0 || stack_ovf || stack_unf) bad++;
        end
        tests_run++;
        if (bad != 0 || pc !== 8'h2C) begin
            failures++;
            $display("FAIL idle_count: %0d bad cycles, final pc=%h, expected 0 bad and pc=2c", bad, pc);
        end
    endtask

    task automatic test_jmp();
        cycle(0, 0, 0, 0, 4'h0, 0, 1);
        idle_to(8'h12);
        cycle(1, 0, 0, 0, 4'hA, 0, 0);
        tests_run++;
        if (obs_pm !== 8'hA0 || pc !== 8'hA0) begin
            failures++;
            $display("FAIL jmp: pm_addr=%h pc=%h, expected a0 a0", obs_pm, pc);
        end
        cycle(1, 0, 1, 0, 4'hA, 0, 0);
        tests_run++;
        if (pc !== 8'hA0 || sp !== 3'd0 || stack_ovf) begin
            failures++;
            $display("FAIL jmp_over_call: pc=%h sp=%0d ovf=%b, expected a0 0 0", pc, sp, stack_ovf);
        end
    endtask

    task automatic test_jmp_nz();
        cycle(0, 1, 0, 0, 4'h3, 0, 0);
        tests_run++;
        if (pc !== 8'h30) begin
            failures++;
            $display("FAIL jmp_nz_taken: pc=%h, expected 30", pc);
        end
        cycle(0, 1, 0, 0, 4'h3, 1, 0);
        tests_run++;
        if (obs_pm !== 8'h31 || pc !== 8'h31) begin
            failures++;
            $display("FAIL jmp_nz_suppressed: pm_addr=%h pc=%h, expected 31 31", obs_pm, pc);
        end
    endtask

    task automatic do_nested_calls();
        cycle(0, 0, 0, 0, 4'h0, 0, 1);
        idle_to(8'h10);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, 4'(k + 2), 0, 0);
    endtask

    task automatic test_nested_calls();
        logic [7:0] ret_exp [4] = '{8'h41, 8'h31, 8'h21, 8'h11};
        do_nested_calls();
        tests_run++;
        if (pc !== 8'h50 || sp !== 3'd4 || stack_ovf) begin
            failures++;
            $display("FAIL nested_call_depth: pc=%h sp=%0d ovf=%b, expected 50 4 0", pc, sp, stack_ovf);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 1, 4'h0, 0, 0);
            tests_run++;
            if (pc !== ret_exp[k] || sp !== 3'(3 - k) || stack_ovf || stack_unf) begin
                failures++;
                $display("FAIL nested_ret%0d: pc=%h sp=%0d, expected %h %0d", k, pc, sp, ret_exp[k], 3 - k);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ret_exp [4] = '{8'h41, 8'h31, 8'h21, 8'h11};
        do_nested_calls();
        idle_to(8'h55);
        cycle(0, 0, 1, 0, 4'h7, 0, 0);
        tests_run++;
        if (pc !== 8'h70 || sp !== 3'd4 || stack_ovf !== 1'b1) begin
            failures++;
            $display("FAIL overflow_call: pc=%h sp=%0d ovf=%b, expected 70 4 1", pc, sp, stack_ovf);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 1, 4'h0, 0, 0);
            tests_run++;
            if (pc !== ret_exp[k] || stack_ovf !== 1'b1) begin
                failures++;
                $display("FAIL overflow_ret%0d: pc=%h ovf=%b, expected %h 1", k, pc, stack_ovf, ret_exp[k]);
            end
        end
        cycle(0, 0, 0, 1, 4'h0, 0, 0);
        tests_run++;
        if (pc !== 8'h12 || sp !== 3'd0 || stack_unf !== 1'b1) begin
            failures++;
            $display("FAIL underflow_ret: pc=%h sp=%0d unf=%b, expected 12 0 1", pc, sp, stack_unf);
        end
    endtask

    task automatic test_wrap_and_reset();
        cycle(0, 0, 0, 0, 4'h0, 0, 1);
        cycle(1, 0, 0, 0, 4'hF, 0, 0);
        idle_to(8'hFF);
        cycle(0, 0, 1, 0, 4'h2, 0, 0);
        cycle(0, 0, 0, 1, 4'h0, 0, 0);
        tests_run++;
        if (pc !== 8'h00 || sp !== 3'd0) begin
            failures++;
            $display("FAIL wrap_push: pc=%h sp=%0d, expected 00 0", pc, sp);
        end
        cycle(0, 0, 0, 1, 4'h0, 0, 0);
        idle_to(8'h55);
        for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0, 4'h2, 0, 0);
        cycle(0, 0, 0, 1, 4'h0, 0, 1);
        tests_run++;
        if (obs_pm !== 8'h00 || obs_state !== 21'h0) begin
            failures++;
            $display("FAIL reset_mid_ret: pm_addr=%h state=%h, expected 00 000000", obs_pm, obs_state);
        end
        cycle(0, 0, 0, 0, 4'h0, 0, 0);
        tests_run++;
        if (pc !== 8'h01) begin
            failures++;
            $display("FAIL post_reset_fetch: pc=%h, expected 01", pc);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        cycle(0, 0, 0, 0, 4'h0, 0, 1);
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  4'($urandom), 1'($urandom), $urandom_range(0, 199) == 0);
            if (obs_pm !== exp_pm || obs_state !== exp_state()) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle%0d: pm_addr=%h state=%h, expected pm_addr=%h state=%h",
                             i, obs_pm, obs_state, exp_pm, exp_state());
            end
        end
        tests_run++;
        if (bad != 0) begin
            failures++;
            $display("FAIL random_total: %0d mismatching cycles, expected 0", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        jmp = 0; jmp_nz = 0; call = 0; ret = 0; jmp_addr = 4'h0; dont_jmp = 0; sync_reset = 1;
        m_pc = 0; m_ovf = 0; m_unf = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_idle();
        test_jmp();
        test_jmp_nz();
        test_nested_calls();
        test_overflow();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
